// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: arbiter state encoding and derived grant-id width shared by rr_scan_arbiter and rr_lowest_pick
package rr_arb_pkg;
   typedef enum logic [1:0] {ARB, HOLD, LOCK} state_e;
   function automatic int id_width(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/rr_lowest_pick.sv
// rr_lowest_pick: one-hot lowest set bit and its index via a log-depth lo_to_hi prefix-OR scan
module rr_lowest_pick import rr_arb_pkg::*; #(
   parameter int n_p = 4,
   localparam int id_w_p = id_width(n_p)
) (
   input  logic [n_p-1:0]    vec,
   output logic [n_p-1:0]    pick,
   output logic [id_w_p-1:0] id
);
   localparam int lv_p = $clog2(n_p);
   logic [n_p-1:0] scan [lv_p+1];
   assign scan[0] = vec;
   for (genvar g = 0; g < lv_p; g++) begin : g_scan
      assign scan[g+1] = scan[g] | (scan[g] << (1 << g));
   end
   assign pick = scan[lv_p] & ~(scan[lv_p] << 1);
   always_comb begin
      id = '0;
      for (int i = 0; i < n_p; i++) id = pick[i] ? id | id_w_p'(i) : id;
   end
endmodule

// File: rtl/rr_scan_arbiter.sv
// rr_scan_arbiter: round-robin arbiter, grant held stable under stall; RR_ARB_LOCK_EN adds a sticky LOCK state
module rr_scan_arbiter import rr_arb_pkg::*; #(
   parameter int num_req_p = 4,
   localparam int id_width_p = id_width(num_req_p)
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   input  logic [num_req_p-1:0]  req_i,
   input  logic                  ready_i,
`ifdef RR_ARB_LOCK_EN
   input  logic                  lock_i,
`endif
   output logic                  v_o,
   output logic [num_req_p-1:0]  grant_o,
   output logic [id_width_p-1:0] grant_id_o
);
   state_e state_r, state_n;
   logic [id_width_p-1:0] ptr_r, ptr_n, hold_id_r, hold_id_n, pick_id;
   logic [num_req_p-1:0] hold_grant_r, hold_grant_n, hi_mask, cand, pick;
   logic lock;
`ifdef RR_ARB_LOCK_EN
   assign lock = lock_i;
`else
   assign lock = 1'b0;
`endif
   always_comb begin
      hi_mask = '0;
      for (int i = 0; i < num_req_p; i++) hi_mask[i] = req_i[i] && i > int'(ptr_r);
      cand = |hi_mask ? hi_mask : req_i;
   end
   rr_lowest_pick #(.n_p(num_req_p)) u_pick (.vec(cand), .pick(pick), .id(pick_id));
   always_comb begin
      state_n = state_r;
      ptr_n = ptr_r;
      hold_grant_n = hold_grant_r;
      hold_id_n = hold_id_r;
      v_o = 1'b0;
      grant_o = '0;
      grant_id_o = '0;
      case (state_r)
         HOLD: begin
            v_o = 1'b1;
            grant_o = hold_grant_r;
            grant_id_o = hold_id_r;
         end
`ifdef RR_ARB_LOCK_EN
         LOCK: begin
            v_o = |(req_i & hold_grant_r);
            grant_o = v_o ? hold_grant_r : '0;
            grant_id_o = v_o ? hold_id_r : '0;
         end
`endif
         default: begin
            v_o = |req_i;
            grant_o = pick;
            grant_id_o = pick_id;
            hold_grant_n = pick;
            hold_id_n = pick_id;
            state_n = v_o ? HOLD : ARB;
         end
      endcase
      // an accepted grant moves the pointer; stalls keep the current state
      if (v_o && ready_i) begin
         ptr_n = grant_id_o;
         hold_grant_n = grant_o;
         hold_id_n = grant_id_o;
         state_n = lock ? LOCK : ARB;
      end
   end
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_r <= ARB;
         ptr_r <= id_width_p'(num_req_p - 1);
         hold_grant_r <= '0;
         hold_id_r <= '0;
      end else begin
         state_r <= state_n;
         ptr_r <= ptr_n;
         hold_grant_r <= hold_grant_n;
         hold_id_r <= hold_id_n;
      end
   end
endmodule

// File: tb/tb_rr_scan_arbiter.sv
// tb_rr_scan_arbiter: scoreboard bench comparing rr_scan_arbiter against a rotating-priority reference model
module tb_rr_scan_arbiter;
   localparam int N = 4;
   logic clk = 1'b0, reset_n = 1'b0, ready = 1'b0, lock = 1'b0;
   logic [N-1:0] req = '0;
   logic v;
   logic [N-1:0] grant;
   logic [1:0] grant_id;
   typedef struct {bit chk; bit v; logic [N-1:0] g; int id;} exp_t;
   exp_t q[$];
   int checks = 0, errors = 0;
   int m_ptr = N - 1, m_hold = 0;
   bit m_held = 0, m_locked = 0;

   always #5 clk = ~clk;

   rr_scan_arbiter #(.num_req_p(N)) dut (
      .clk_i(clk),
      .reset_n_i(reset_n),
      .req_i(req),
      .ready_i(ready),
`ifdef RR_ARB_LOCK_EN
      .lock_i(lock),
`endif
      .v_o(v),
      .grant_o(grant),
      .grant_id_o(grant_id)
   );

   function automatic void cmp(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endfunction

   task automatic step(input logic [N-1:0] r, input bit rdy, input bit lk, input bit rst);
      exp_t e;
      bit vv;
      int id;
      @(posedge clk);
      #1;
      req = r;
      ready = rdy;
      lock = lk;
      reset_n = ~rst;
      if (rst) begin
         e = '{0, 0, '0, 0};
         q.push_back(e);
         m_ptr = N - 1;
         m_held = 0;
         m_locked = 0;
         return;
      end
      vv = 0;
      id = 0;
      if (m_locked) begin
         vv = r[m_hold];
         id = m_hold;
      end else if (m_held) begin
         vv = 1;
         id = m_hold;
      end else begin
         for (int k = 1; k <= N; k++)
            if (!vv && r[(m_ptr + k) % N]) begin
               vv = 1;
               id = (m_ptr + k) % N;
            end
      end
      e.chk = 1;
      e.v = vv;
      e.g = '0;
      if (vv) e.g[id] = 1'b1;
      e.id = vv ? id : 0;
      q.push_back(e);
      if (vv && rdy) begin
         m_ptr = id;
         m_held = 0;
         m_hold = id;
`ifdef RR_ARB_LOCK_EN
         m_locked = lk;
`endif
      end else if (vv && !m_locked && !m_held) begin
         m_held = 1;
         m_hold = id;
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk) begin
               cmp("v_o", int'(v), int'(e.v));
               cmp("grant_o", int'(grant), int'(e.g));
               cmp("grant_id_o", int'(grant_id), e.id);
            end
         end
      end
   end

   initial begin
      step('0, 0, 0, 1);
      step('0, 0, 0, 0);
      step('0, 1, 0, 0);
      repeat (5) step(4'b1111, 1, 0, 0);
      step('0, 0, 0, 1);
      repeat (3) step(4'b1010, 1, 0, 0);
      step('0, 0, 0, 1);
      step(4'b0110, 0, 0, 0);
      step(4'b0100, 0, 0, 0);
      step(4'b0100, 0, 0, 0);
      step(4'b0100, 1, 0, 0);
      step(4'b0100, 1, 0, 0);
      step('0, 0, 0, 1);
      repeat (3) step('0, 1, 0, 0);
      step(4'b1000, 1, 0, 0);
      step('0, 0, 0, 1);
      repeat (2) step(4'b1111, 1, 0, 0);
      step(4'b1111, 0, 0, 0);
      step(4'b1111, 0, 0, 1);
      step(4'b1111, 1, 0, 0);
`ifdef RR_ARB_LOCK_EN
      step('0, 0, 0, 1);
      step(4'b1111, 1, 0, 0);
      repeat (3) step(4'b1111, 1, 1, 0);
      step(4'b1111, 1, 0, 0);
      step(4'b1111, 1, 0, 0);
`endif
      for (int i = 0; i < 400; i++)
         step(N'($urandom_range(0, 15)), $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 49) == 0);
      @(posedge clk);
      for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
